// File: rtl/imem_loader.sv
// Byte-serial loader for the instruction memory.
// Holds the CPU in reset until a checksummed image lands.
module imem_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count
);

  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_B = BW'(NB - 1);
  localparam int MAX_L = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_rdy;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [N-1:0]        r_wdata;
  logic [N-1:0]        r_word;
  logic [N-1:0]        w_word;
  logic [BW-1:0]       r_bidx;
  logic [7:0]          r_xor;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_wc;
  logic [ADDR_W:0]     w_wc_inc;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_hold;
  logic                w_acc;
  logic                w_last_b;
  logic                w_len_ok;

  assign w_acc    = rx_valid & r_rdy;
  assign w_last_b = (r_bidx == LAST_B);
  assign w_wc_inc = r_wc + (ADDR_W+1)'(1);
  assign w_len_ok = (rx_data != 8'd0) &&
                    (int'(rx_data) <= MAX_L);

  // Merge the incoming byte into its lane of the word
  always_comb begin
    w_word = r_word;
    w_word[{r_bidx, 3'b000} +: 8] = rx_data;
  end

  // Session state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: framing of length, data and checksum bytes
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR:
        if (start) w_next = S_LEN;
      S_LEN:
        if (w_acc) w_next = w_len_ok ? S_DATA : S_ERR;
      S_DATA:
        if (w_acc && w_last_b && (w_wc_inc == r_len))
          w_next = S_CHK;
      S_CHK:
        if (w_acc)
          w_next = (rx_data == r_xor) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: word assembly, write pulse, checksum and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy   <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_bidx  <= '0;
      r_xor   <= '0;
      r_len   <= '0;
      r_wc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= 1'b1;
    end else begin
      r_we  <= 1'b0;
      r_rdy <= (w_next == S_LEN) ||
               (w_next == S_DATA) ||
               (w_next == S_CHK);
      // advance after a write, but stop on the last word
      if (r_we && (r_wc != r_len))
        r_waddr <= r_waddr + ADDR_W'(1);
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wc    <= '0;
            r_xor   <= '0;
            r_bidx  <= '0;
            r_waddr <= '0;
            r_busy  <= 1'b1;
            r_hold  <= 1'b1;
          end
        end
        S_LEN: begin
          if (w_acc) begin
            if (w_len_ok) begin
              r_len   <= (ADDR_W+1)'(rx_data);
              r_waddr <= '0;
              r_bidx  <= '0;
            end else begin
              r_err  <= 1'b1;
              r_busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_xor  <= r_xor ^ rx_data;
            r_word <= w_word;
            r_bidx <= r_bidx + BW'(1);
            if (w_last_b) begin
              r_wdata <= w_word;
              r_we    <= 1'b1;
              r_wc    <= w_wc_inc;
              r_bidx  <= '0;
            end
          end
        end
        S_CHK: begin
          if (w_acc) begin
            r_busy <= 1'b0;
            if (rx_data == r_xor) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready   = r_rdy;
  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign cpu_hold   = r_hold;
  assign word_count = r_wc;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random frames against a
// frame-level model of words, addresses and checksum.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;
  logic [6:0]  word_count;

  imem_loader #(.N(32), .ADDR_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .err(err),
    .cpu_hold(cpu_hold), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [7:0]  fr[$];
  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wt_q[$];
  int          acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (we === 1'b1) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      wt_q.push_back(cyc);
    end

  // ---------------- model ----------------
  task automatic make_frame(input int L, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    fr.delete();
    fr.push_back(8'(L));
    x = 8'h00;
    for (int i = 0; i < 4 * L; i++) begin
      b = 8'($urandom);
      fr.push_back(b);
      x = x ^ b;
    end
    if (good) fr.push_back(x);
    else fr.push_back(x ^ 8'($urandom_range(255, 1)));
  endtask

  function automatic int m_len();
    return int'(fr[0]);
  endfunction

  function automatic logic [31:0] m_word(input int i);
    return {fr[4*i+4], fr[4*i+3], fr[4*i+2], fr[4*i+1]};
  endfunction

  function automatic bit m_good();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < fr.size() - 1; i++) x = x ^ fr[i];
    return x == fr[fr.size()-1];
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    int n;
    bit a;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    a = 1'b0;
    while (!a && n < 40) begin
      @(negedge clk);
      a = rx_ready;
      tick();
      n++;
    end
    if (!a) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: rx_ready=%b, required 1",
               rx_ready);
    end else acc_cyc = cyc;
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    wt_q.delete();
    acc_q.delete();
  endtask

  task automatic send_frame(input int gapmax, input int start_at);
    clear_q();
    pulse_start();
    foreach (fr[i]) begin
      if (i == start_at) pulse_start();
      send_byte(fr[i], gapmax);
      acc_q.push_back(acc_cyc);
    end
    rx_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rx_ready, we, busy, done, err, cpu_hold} !== 6'b000001) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 000001",
               {rx_ready, we, busy, done, err, cpu_hold});
    end
    vectors++;
    if ({waddr, wdata, word_count} !== 45'd0) begin
      miscompares++;
      $display("FAIL reset_data: waddr=%h wdata=%h wc=%0d, required 0",
               waddr, wdata, word_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_good_single();
    fr = '{8'h01, 8'hFE, 8'h03, 8'h1F, 8'h8B, 8'h69};
    clear_q();
    pulse_start();
    @(negedge clk);
    vectors++;
    if ({rx_ready, busy, done, cpu_hold} !== 4'b1101) begin
      miscompares++;
      $display("FAIL start_flags: got %b, required 1101",
               {rx_ready, busy, done, cpu_hold});
    end
    tick();
    foreach (fr[i]) begin
      send_byte(fr[i], 0);
      acc_q.push_back(acc_cyc);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (wa_q.size() != 1 || wa_q[0] !== 6'd0 ||
        wd_q[0] !== 32'h8B1F03FE) begin
      miscompares++;
      $display("FAIL single_write: n=%0d waddr=%h wdata=%h, required 1/0/8b1f03fe",
               wa_q.size(), wa_q.size() ? wa_q[0] : 6'd0,
               wd_q.size() ? wd_q[0] : 32'd0);
    end
    vectors++;
    if (wt_q.size() != 1 || wt_q[0] != acc_q[4]) begin
      miscompares++;
      $display("FAIL single_latency: we cycle %0d, required %0d",
               wt_q.size() ? wt_q[0] : -1, acc_q[4]);
    end
    vectors++;
    if ({done, err, cpu_hold, busy, word_count} !== {4'b1000, 7'd1}) begin
      miscompares++;
      $display("FAIL single_status: d/e/h/b=%b wc=%0d, required 1000 wc=1",
               {done, err, cpu_hold, busy}, word_count);
    end
  endtask

  task automatic test_bad_checksum();
    fr = '{8'h01, 8'hFE, 8'h03, 8'h1F, 8'h8B, 8'h68};
    send_frame(0, -1);
    @(negedge clk);
    vectors++;
    if (wa_q.size() != 1 || wd_q[0] !== m_word(0)) begin
      miscompares++;
      $display("FAIL bad_write: n=%0d, required 1 word %h",
               wa_q.size(), m_word(0));
    end
    vectors++;
    if ({done, err, cpu_hold, busy} !== 4'b0110) begin
      miscompares++;
      $display("FAIL bad_status: d/e/h/b=%b, required 0110",
               {done, err, cpu_hold, busy});
    end
  endtask

  task automatic test_illegal_len();
    logic [7:0] lens[3];
    lens = '{8'h00, 8'h41, 8'hFF};
    foreach (lens[k]) begin
      clear_q();
      pulse_start();
      send_byte(lens[k], 0);
      rx_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({err, done, rx_ready, busy, cpu_hold} !== 5'b10001) begin
        miscompares++;
        $display("FAIL illegal_len_%h: e/d/r/b/h=%b, required 10001",
                 lens[k], {err, done, rx_ready, busy, cpu_hold});
      end
      repeat (3) tick();
      vectors++;
      if (wa_q.size() != 0) begin
        miscompares++;
        $display("FAIL illegal_len_we_%h: %0d writes, required 0",
                 lens[k], wa_q.size());
      end
    end
  endtask

  task automatic test_full_image();
    int bad;
    make_frame(64, 1'b1);
    send_frame(0, -1);
    @(negedge clk);
    vectors++;
    if (acc_q[acc_q.size()-1] - acc_q[0] != fr.size() - 1) begin
      miscompares++;
      $display("FAIL full_throughput: %0d cycles, required %0d",
               acc_q[acc_q.size()-1] - acc_q[0], fr.size() - 1);
    end
    vectors++;
    if (wa_q.size() != 64) begin
      miscompares++;
      $display("FAIL full_count: %0d writes, required 64", wa_q.size());
    end
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 64; i++) begin
      if (wa_q[i] !== 6'(i) || wd_q[i] !== m_word(i)) bad++;
      if (i > 0 && wt_q[i] - wt_q[i-1] != 4) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL full_words: %0d bad addr/data/spacing, required 0",
               bad);
    end
    vectors++;
    if ({done, err, cpu_hold} !== 3'b100 || word_count !== 7'd64 ||
        waddr !== 6'd63) begin
      miscompares++;
      $display("FAIL full_status: d/e/h=%b wc=%0d waddr=%0d, required 100/64/63",
               {done, err, cpu_hold}, word_count, waddr);
    end
  endtask

  task automatic test_reset_mid();
    make_frame(5, 1'b1);
    clear_q();
    pulse_start();
    for (int i = 0; i < 15; i++) send_byte(fr[i], 0);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({we, busy, cpu_hold, rx_ready, word_count} !== {4'b0010, 7'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: we/b/h/r=%b wc=%0d, required 0010 wc=0",
               {we, busy, cpu_hold, rx_ready}, word_count);
    end
    rx_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    make_frame(1, 1'b1);
    send_frame(0, -1);
    @(negedge clk);
    vectors++;
    if (wa_q.size() != 1 || wa_q[0] !== 6'd0 || wd_q[0] !== m_word(0) ||
        done !== 1'b1 || word_count !== 7'd1) begin
      miscompares++;
      $display("FAIL reset_reload: n=%0d done=%b wc=%0d, required 1/1/1",
               wa_q.size(), done, word_count);
    end
  endtask

  task automatic test_stall_start();
    int L;
    int bad;
    L = int'($urandom_range(6, 2));
    make_frame(L, 1'b1);
    send_frame(3, 6);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < L; i++) begin
      if (wa_q[i] !== 6'(i) || wd_q[i] !== m_word(i)) bad++;
      if (wt_q[i] != acc_q[4*i+4]) bad++;
    end
    vectors++;
    if (wa_q.size() != L || bad != 0) begin
      miscompares++;
      $display("FAIL stall_words: n=%0d bad=%0d, required n=%0d bad=0",
               wa_q.size(), bad, L);
    end
    vectors++;
    if ({done, err, cpu_hold, busy} !== 4'b1000 || word_count !== 7'(L)) begin
      miscompares++;
      $display("FAIL stall_status: d/e/h/b=%b wc=%0d, required 1000 wc=%0d",
               {done, err, cpu_hold, busy}, word_count, L);
    end
  endtask

  task automatic test_random_frames();
    int L;
    int bad;
    bit g;
    for (int k = 0; k < 6; k++) begin
      L = int'($urandom_range(10, 1));
      make_frame(L, 1'($urandom_range(1, 0)));
      g = m_good();
      send_frame(2, -1);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < wa_q.size() && i < L; i++)
        if (wa_q[i] !== 6'(i) || wd_q[i] !== m_word(i)) bad++;
      vectors++;
      if (wa_q.size() != m_len() || bad != 0) begin
        miscompares++;
        $display("FAIL rand_words_%0d: n=%0d bad=%0d, required n=%0d bad=0",
                 k, wa_q.size(), bad, m_len());
      end
      vectors++;
      if ({done, err, cpu_hold, busy} !== {g, !g, !g, 1'b0}) begin
        miscompares++;
        $display("FAIL rand_status_%0d: d/e/h/b=%b, required %b",
                 k, {done, err, cpu_hold, busy}, {g, !g, !g, 1'b0});
      end
    end
  endtask

  initial begin
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    reset_n = 1'b0;
    test_reset();
    test_good_single();
    test_bad_checksum();
    test_illegal_len();
    test_full_image();
    test_reset_mid();
    test_stall_start();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader that fills the processor's 64-word instruction memory through a write port, replacing the hard-coded initial contents with a runtime download. It sits between a byte source (UART receiver or testbench) and the instruction RAM's write port. It keeps the CPU held in reset until a complete, checksum-verified program has been written.

## Interface
- N, 32, instruction word width (bits); must be a multiple of 8
- ADDR_W, 6, instruction memory address width (2^ADDR_W = 64 words)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load session; single-cycle pulse
- rx_valid  in  1  rx_data holds a byte
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader accepts a byte this cycle
- we  out  1  instruction memory write enable, one-cycle pulse per word
- waddr  out  ADDR_W  word address for the write
- wdata  out  N  assembled instruction word
- busy  out  1  session in progress
- done  out  1  last session completed with a good checksum
- err  out  1  last session failed
- cpu_hold  out  1  keep the processor in reset
- word_count  out  ADDR_W+1  words written in the current or last session

## Operation
- Handshake: a byte is accepted on a rising edge where rx_valid and rx_ready are both 1. The source must hold rx_data stable while rx_valid=1 and rx_ready=0.
- Frame format, in order:
  - length byte L: word count, legal range 1..64
  - 4·L data bytes, little-endian per word, words in address order starting at 0
  - checksum byte: XOR of all data bytes. The length byte is excluded.
- States:
  - IDLE: rx_ready=0. A start pulse goes to LEN, clears done, err, word_count and the running XOR, and sets busy and cpu_hold.
  - LEN: rx_ready=1.
    - L=0 or L>64: go to ERR.
    - Otherwise: latch L, waddr←0, go to DATA.
  - DATA: rx_ready=1. Shift bytes into the word register; byte k of a word lands in bits [8k+7:8k]. XOR every byte into the checksum.
    - On the 4th byte of a word: register wdata, pulse we, and present the current waddr.
    - After the write: waddr++ and word_count++.
    - After word L is written: go to CHK.
  - CHK: rx_ready=1.
    - Received byte equals running XOR: go to DONE (done=1, busy=0, cpu_hold=0).
    - Otherwise: go to ERR (err=1, busy=0, cpu_hold=1).
  - DONE / ERR: rx_ready=0. Outputs hold. A start pulse begins a new session exactly as from IDLE.
- start while busy=1 is ignored.
- waddr never exceeds L−1 and never wraps; L=64 writes addresses 0..63.
- Words written before a failure stay in memory. cpu_hold stays high, so the CPU never runs a bad image.

## Timing
- Reset (reset_n=0, asynchronous): state IDLE; rx_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, word_count=0, cpu_hold=1.
- Reset asserted mid-session aborts immediately with the same values. A we pulse in flight is dropped.
- start is sampled at edge t. rx_ready=1 from cycle t+1.
- Throughput: one byte per cycle while rx_valid stays high. rx_ready is not deasserted between bytes within LEN, DATA or CHK.
- Write latency: 4th byte accepted at edge t → we=1 with matching waddr/wdata during cycle t+1, we=0 at t+2. Back-to-back words produce we pulses 4 cycles apart.
- Checksum accepted at edge t → done or err, busy=0 and cpu_hold (if DONE) valid in cycle t+1.
- rx_valid gaps only stall progress. No timeout exists.
- All outputs are registered.

## Test plan
- Good single word: start, bytes 01,FE,03,1F,8B,69 → one we pulse with waddr=0, wdata=0x8B1F03FE; then done=1, err=0, cpu_hold=0, word_count=1.
- Bad checksum: same frame with final byte 68 → word still written; err=1, done=0, cpu_hold=1, busy=0.
- Illegal length: bytes 00, and separately 41 → err=1 the cycle after the length byte, no we pulse, rx_ready=0.
- Full image with rx_valid held high: L=0x40, 256 data bytes, correct XOR → 64 we pulses 4 cycles apart, waddr 0..63 with no wrap; done=1, word_count=64.
- Reset mid-DATA: reset_n low after 2 bytes of word 3 → immediately we=0, busy=0, cpu_hold=1. A new start plus a 1-word frame loads correctly at waddr=0.
- Stalls and ignored start: random rx_valid gaps plus a start pulse during DATA → data and we sequence identical to the no-stall run, and the session is not restarted.
